// File: rtl/lockin_demod_mixer.sv
// Lock-in demodulator front end: NCO, quarter-wave sine ROM and I/Q mixers.
// Five register stages from an accepted ADC sample to its out_tick strobe.
module lockin_demod_mixer #(
    parameter int ADC_W  = 16,
    parameter int LUT_AW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_tick,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [31:0]      freq_word,
    input  logic [31:0]      phase_off,
    output logic [31:0]      i_out,
    output logic [31:0]      q_out,
    output logic             out_tick,
    output logic             ref_sq
);

    localparam int PW  = LUT_AW + 2;
    localparam int LO  = 32 - PW;
    localparam int LN  = 1 << LUT_AW;
    localparam int PRW = 2 * ADC_W;

    // Half-step sample points keep the quarter-wave mirror exact.
    function automatic logic [15:0] lut_val(input int k);
        real x;
        real term;
        real acc;
        x = 3.14159265358979323846 * ($itor(k) + 0.5) / $itor(2 * LN);
        term = x;
        acc = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc = acc + term;
        end
        return 16'($rtoi(32767.0 * acc + 0.5));
    endfunction

    logic [15:0] w_lut [LN];

    for (genvar k = 0; k < LN; k++) begin : g_lut
        localparam logic [15:0] LV = lut_val(k);
        assign w_lut[k] = LV;
    end

    logic                    r_last;
    logic [31:0]             r_acc;
    logic                    r_sq;

    logic                    r_v1;
    logic signed [ADC_W-1:0] r_adc1;
    logic [PW-1:0]           r_p1;

    logic                    r_v2;
    logic signed [ADC_W-1:0] r_adc2;
    logic                    r_neg_s2;
    logic                    r_neg_c2;
    logic [LUT_AW-1:0]       r_addr_s2;
    logic [LUT_AW-1:0]       r_addr_c2;

    logic                    r_v3;
    logic signed [ADC_W-1:0] r_adc3;
    logic                    r_neg_s3;
    logic                    r_neg_c3;
    logic [15:0]             r_lut_s3;
    logic [15:0]             r_lut_c3;

    logic                    r_v4;
    logic signed [ADC_W-1:0] r_adc4;
    logic signed [15:0]      r_ref_s4;
    logic signed [15:0]      r_ref_c4;

    logic                    r_tick;
    logic [PRW-1:0]          r_i;
    logic [PRW-1:0]          r_q;

    logic                    w_acc;
    logic [LO-1:0]           w_lo;
    logic                    w_cy;
    logic [PW-1:0]           w_ph;
    logic [PW-1:0]           w_pc;
    logic signed [PRW-1:0]   w_prod_i;
    logic signed [PRW-1:0]   w_prod_q;

    assign w_acc = adc_tick && !r_last;

    // Only the top phase bits reach the ROM; the low half just supplies a carry.
    assign w_lo = r_acc[LO-1:0] + phase_off[LO-1:0];
    assign w_cy = w_lo < r_acc[LO-1:0];
    assign w_ph = r_acc[31 -: PW] + phase_off[31 -: PW] + PW'(w_cy);

    assign w_pc = r_p1 + PW'(LN);

    assign w_prod_i = PRW'(r_adc4) * PRW'(r_ref_c4);
    assign w_prod_q = PRW'(r_adc4) * PRW'(r_ref_s4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
            r_acc  <= '0;
            r_sq   <= 1'b0;
        end else begin
            r_last <= adc_tick;
            r_sq   <= r_acc[31];
            if (w_acc) begin
                r_acc <= r_acc + freq_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_adc1    <= '0;
            r_p1      <= '0;
            r_v2      <= 1'b0;
            r_adc2    <= '0;
            r_neg_s2  <= 1'b0;
            r_neg_c2  <= 1'b0;
            r_addr_s2 <= '0;
            r_addr_c2 <= '0;
            r_v3      <= 1'b0;
            r_adc3    <= '0;
            r_neg_s3  <= 1'b0;
            r_neg_c3  <= 1'b0;
            r_lut_s3  <= '0;
            r_lut_c3  <= '0;
            r_v4      <= 1'b0;
            r_adc4    <= '0;
            r_ref_s4  <= '0;
            r_ref_c4  <= '0;
            r_tick    <= 1'b0;
            r_i       <= '0;
            r_q       <= '0;
        end else begin
            r_v1 <= w_acc;
            if (w_acc) begin
                r_adc1 <= adc_data;
                r_p1   <= w_ph;
            end

            r_v2      <= r_v1;
            r_adc2    <= r_adc1;
            r_neg_s2  <= r_p1[PW-1];
            r_neg_c2  <= w_pc[PW-1];
            r_addr_s2 <= r_p1[LUT_AW] ? ~r_p1[LUT_AW-1:0] : r_p1[LUT_AW-1:0];
            r_addr_c2 <= w_pc[LUT_AW] ? ~w_pc[LUT_AW-1:0] : w_pc[LUT_AW-1:0];

            r_v3     <= r_v2;
            r_adc3   <= r_adc2;
            r_neg_s3 <= r_neg_s2;
            r_neg_c3 <= r_neg_c2;
            r_lut_s3 <= w_lut[r_addr_s2];
            r_lut_c3 <= w_lut[r_addr_c2];

            r_v4     <= r_v3;
            r_adc4   <= r_adc3;
            r_ref_s4 <= r_neg_s3 ? -r_lut_s3 : r_lut_s3;
            r_ref_c4 <= r_neg_c3 ? -r_lut_c3 : r_lut_c3;

            r_tick <= r_v4;
            if (r_v4) begin
                r_i <= w_prod_i;
                r_q <= w_prod_q;
            end
        end
    end

    assign i_out    = r_i;
    assign q_out    = r_q;
    assign out_tick = r_tick;
    assign ref_sq   = r_sq;

endmodule

// File: tb/tb_lockin_demod_mixer.sv
// Bench for lockin_demod_mixer: directed cases plus random traffic
// checked each cycle against an ideal sine-table mixer model.
module tb_lockin_demod_mixer;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_tick;
    logic [15:0] adc_data;
    logic [31:0] freq_word;
    logic [31:0] phase_off;
    logic [31:0] i_out;
    logic [31:0] q_out;
    logic        out_tick;
    logic        ref_sq;

    always #5 clk = ~clk;

    lockin_demod_mixer dut (
        .clk       (clk),
        .rst       (rst),
        .adc_tick  (adc_tick),
        .adc_data  (adc_data),
        .freq_word (freq_word),
        .phase_off (phase_off),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_tick  (out_tick),
        .ref_sq    (ref_sq)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    typedef struct {
        int due;
        int iv;
        int qv;
    } pend_t;

    pend_t       pq[$];
    int          sin_t[1024];
    logic [31:0] m_acc;
    logic        m_last;
    logic        m_tick;
    logic        m_sq;
    int          m_i;
    int          m_q;
    int          cyc = 0;
    int          obs_i[$];
    int          obs_q[$];
    int          obs_c[$];

    int t1_i[4] = '{536854528, -1654784, -536854528, 1654784};
    int t1_q[4] = '{1654784, 536854528, -1654784, -536854528};
    int t4_i[4] = '{655340000, 2020000, -655340000, -2020000};
    int t4_sq[4] = '{1, 1, 0, 0};

    // Ideal mixer: 1024-point sine at half-step angles, cos = sin + 90 deg.
    task automatic model_step();
        logic [31:0] ph;
        int j;
        int a;
        if (rst) begin
            m_acc  = '0;
            m_last = 1'b0;
            m_tick = 1'b0;
            m_sq   = 1'b0;
            m_i    = 0;
            m_q    = 0;
            pq.delete();
        end else begin
            m_sq   = m_acc[31];
            m_tick = 1'b0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                m_i    = pq[0].iv;
                m_q    = pq[0].qv;
                m_tick = 1'b1;
                void'(pq.pop_front());
            end
            if (adc_tick && !m_last) begin
                ph = m_acc + phase_off;
                j  = int'(ph >> 22);
                a  = int'($signed(adc_data));
                pq.push_back('{cyc + 4, a * sin_t[(j + 256) % 1024], a * sin_t[j]});
                m_acc = m_acc + freq_word;
            end
            m_last = adc_tick;
        end
    endtask

    task automatic step(input logic t, input logic [15:0] d);
        adc_tick = t;
        adc_data = d;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("out_tick", {31'd0, out_tick}, {31'd0, m_tick});
        chk("i_out", i_out, m_i);
        chk("q_out", q_out, m_q);
        chk("ref_sq", {31'd0, ref_sq}, {31'd0, m_sq});
        if (out_tick) begin
            obs_i.push_back(int'(i_out));
            obs_q.push_back(int'(q_out));
            obs_c.push_back(cyc);
        end
    endtask

    task automatic clear_obs();
        obs_i.delete();
        obs_q.delete();
        obs_c.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'd0);
        step(1'b0, 16'd0);
        rst = 1'b0;
    endtask

    task automatic accept(input logic [15:0] d);
        step(1'b1, d);
        step(1'b0, d);
    endtask

    initial begin
        int drv;
        logic t;
        logic [15:0] d;

        for (int j = 0; j < 1024; j++) begin
            real v;
            v = 32767.0 * $sin(2.0 * PI * ($itor(j) + 0.5) / 1024.0);
            sin_t[j] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        end

        rst = 1'b1;
        adc_tick = 1'b0;
        adc_data = '0;
        freq_word = 32'h4000_0000;
        phase_off = '0;

        // quadrature sweep at quarter-cycle steps
        do_reset();
        chk("rst_i", i_out, 32'd0);
        chk("rst_q", q_out, 32'd0);
        clear_obs();
        repeat (4) accept(16'd16384);
        repeat (6) step(1'b0, 16'd16384);
        chk("t1_cnt", obs_i.size(), 4);
        if (obs_i.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t1_i%0d", k), obs_i[k], t1_i[k]);
                chk($sformatf("t1_q%0d", k), obs_q[k], t1_q[k]);
            end
        end

        // full-scale negative sample
        freq_word = 32'h8000_0000;
        do_reset();
        clear_obs();
        repeat (2) accept(16'h8000);
        repeat (6) step(1'b0, 16'h8000);
        chk("t2_cnt", obs_i.size(), 2);
        if (obs_i.size() == 2) begin
            chk("t2_i0", obs_i[0], -1073709056);
            chk("t2_q0", obs_q[0], -3309568);
            chk("t2_i1", obs_i[1], 1073709056);
            chk("t2_q1", obs_q[1], 3309568);
        end

        // held tick: single accept, fixed latency
        freq_word = 32'h1234_5678;
        do_reset();
        clear_obs();
        drv = cyc;
        repeat (10) step(1'b1, 16'd777);
        repeat (8) step(1'b0, 16'd777);
        chk("t3_cnt", obs_c.size(), 1);
        if (obs_c.size() == 1) begin
            chk("t3_lat", obs_c[0] - drv, 5);
        end

        // accumulator wrap and excitation square wave
        freq_word = 32'hC000_0000;
        do_reset();
        clear_obs();
        for (int k = 0; k < 4; k++) begin
            accept(16'd20000);
            chk($sformatf("t4_sq%0d", k), {31'd0, ref_sq}, t4_sq[k]);
        end
        repeat (6) step(1'b0, 16'd20000);
        chk("t4_cnt", obs_i.size(), 4);
        if (obs_i.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t4_i%0d", k), obs_i[k], t4_i[k]);
            end
        end

        // phase offset only touches the demodulation phase
        freq_word = '0;
        phase_off = 32'h4000_0000;
        do_reset();
        clear_obs();
        repeat (3) accept(16'd1000);
        repeat (6) step(1'b0, 16'd1000);
        chk("t5_cnt", obs_i.size(), 3);
        if (obs_i.size() == 3) begin
            chk("t5_q0", obs_q[0], 32767000);
            chk("t5_i0", obs_i[0], -101000);
            chk("t5_q2", obs_q[2], 32767000);
        end
        chk("t5_sq", {31'd0, ref_sq}, 32'd0);

        // reset flushes samples in flight
        freq_word = 32'h4000_0000;
        phase_off = '0;
        do_reset();
        accept(16'd5000);
        accept(16'd5000);
        clear_obs();
        rst = 1'b1;
        step(1'b1, 16'd5000);
        rst = 1'b0;
        repeat (8) step(1'b0, 16'd5000);
        chk("t6_cnt", obs_i.size(), 0);
        chk("t6_i", i_out, 32'd0);
        chk("t6_q", q_out, 32'd0);
        chk("t6_sq", {31'd0, ref_sq}, 32'd0);
        accept(16'd5000);
        repeat (5) step(1'b0, 16'd5000);
        chk("t6_cnt2", obs_i.size(), 1);
        if (obs_i.size() == 1) begin
            chk("t6_i0", obs_i[0], 163835000);
        end

        // random traffic
        freq_word = $urandom;
        phase_off = $urandom;
        t = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                freq_word = $urandom;
                phase_off = $urandom;
            end
            rst = ($urandom_range(0, 499) == 0);
            t = ($urandom_range(0, 2) == 0);
            d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) d = 16'h8000;
            step(t, d);
        end
        rst = 1'b0;
        repeat (8) step(1'b0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
